// File: rtl/ocm_avmm_if.sv
// Avalon-MM pipelined command/response bundle between the OCM bridge master and the memory responder.
interface ocm_avmm_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0]   s0_address;
    logic                s0_read;
    logic                s0_write;
    logic [DATA_W-1:0]   s0_writedata;
    logic [DATA_W/8-1:0] s0_byteenable;
    logic                s0_burstcount;
    logic                s0_debugaccess;
    logic                s0_waitrequest;
    logic [DATA_W-1:0]   s0_readdata;
    logic                s0_readdatavalid;

    modport master (
        output s0_address, s0_read, s0_write, s0_writedata, s0_byteenable,
               s0_burstcount, s0_debugaccess,
        input  s0_waitrequest, s0_readdata, s0_readdatavalid
    );

    modport slave (
        input  s0_address, s0_read, s0_write, s0_writedata, s0_byteenable,
               s0_burstcount, s0_debugaccess,
        output s0_waitrequest, s0_readdata, s0_readdatavalid
    );
endinterface

// File: rtl/ocm_avmm_responder.sv
// On-chip word memory behind an Avalon-MM pipelined slave: fixed-latency reads, bounded
// outstanding reads, write protection of a low region and a saturating protocol-error counter.
module ocm_avmm_responder #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 128,
    parameter int MEM_AW     = 8,
    parameter int READ_LAT   = 2,
    parameter int MAX_PEND   = 4,
    parameter int PROT_WORDS = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    ocm_avmm_if.slave   s0,
    output logic [15:0] err_count
);
    localparam int BE_W   = DATA_W / 8;
    localparam int WI_W   = ADDR_W - 4;
    localparam int PEND_W = 4;

    logic                ready;
    logic [PEND_W-1:0]   pend;
    logic [READ_LAT-1:0] rd_valid_pipe;
    logic [DATA_W-1:0]   rd_data_pipe [READ_LAT];
    logic [DATA_W-1:0]   mem [2**MEM_AW];

    logic [WI_W-1:0]     word_idx;
    logic [MEM_AW-1:0]   mem_idx;
    logic                in_range;
    logic                prot_hit;
    logic                proto_err;
    logic                accept;
    logic                do_write;
    logic                do_read;
    logic                mem_we;
    logic                err_evt;
    logic [DATA_W-1:0]   rd_word;

    assign word_idx  = s0.s0_address[ADDR_W-1:4];
    assign mem_idx   = word_idx[MEM_AW-1:0];
    assign in_range  = (word_idx[WI_W-1:MEM_AW] == '0);
    assign prot_hit  = (word_idx < WI_W'(PROT_WORDS)) && !s0.s0_debugaccess;
    assign proto_err = (s0.s0_burstcount != 1'b1) || (s0.s0_read && s0.s0_write)
                     || (s0.s0_address[3:0] != 4'd0);

    // Built only from flops so the master never sees a combinational path back from its own request.
    assign s0.s0_waitrequest = !ready || (pend == PEND_W'(MAX_PEND));

    assign accept   = (s0.s0_read || s0.s0_write) && !s0.s0_waitrequest;
    assign do_write = accept && s0.s0_write;
    assign do_read  = accept && s0.s0_read && !s0.s0_write;
    assign mem_we   = do_write && in_range && !prot_hit;
    assign err_evt  = accept && (proto_err || !in_range || (s0.s0_write && prot_hit));
    assign rd_word  = in_range ? mem[mem_idx] : '0;

    assign s0.s0_readdatavalid = rd_valid_pipe[READ_LAT-1];
    assign s0.s0_readdata      = rd_data_pipe[READ_LAT-1];

    // NOTE: the storage array has no reset branch; clearing it would turn it into flops and block RAM inference.
    always_ff @(posedge clk_clk) begin
        if (mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (s0.s0_byteenable[i]) begin
                    mem[mem_idx][8*i +: 8] <= s0.s0_writedata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: every state register below uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ready         <= 1'b0;
            pend          <= '0;
            rd_valid_pipe <= '0;
            err_count     <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                rd_data_pipe[i] <= '0;
            end
        end else begin
            ready            <= 1'b1;
            rd_valid_pipe[0] <= do_read;
            rd_data_pipe[0]  <= rd_word;
            for (int i = 1; i < READ_LAT; i++) begin
                rd_valid_pipe[i] <= rd_valid_pipe[i-1];
                rd_data_pipe[i]  <= rd_data_pipe[i-1];
            end

            if (do_read && !s0.s0_readdatavalid) begin
                pend <= pend + 1'b1;
            end else if (!do_read && s0.s0_readdatavalid) begin
                pend <= pend - 1'b1;
            end

            if (err_evt && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_ocm_avmm_responder.sv
// Directed bench for ocm_avmm_responder: a memory/error model feeds a response scoreboard
// checked by a monitor; a second long-latency instance exercises the outstanding-read limit.
module tb_ocm_avmm_responder;
    typedef struct {
        logic [127:0] data;
        int           due;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] err_a;
    logic [15:0] err_b;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    rsp_t         sb [$];
    logic [127:0] mem_m [256];
    logic [15:0]  err_m = 16'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ocm_avmm_if #(.ADDR_W(18), .DATA_W(128)) bus ();
    ocm_avmm_if #(.ADDR_W(18), .DATA_W(128)) bus_b ();

    ocm_avmm_responder #(.READ_LAT(2), .MAX_PEND(4)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .s0(bus), .err_count(err_a)
    );

    ocm_avmm_responder #(.READ_LAT(6), .MAX_PEND(4)) dut_b (
        .clk_clk(clk), .reset_reset_n(rst_n), .s0(bus_b), .err_count(err_b)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every readdatavalid must match the oldest queued expectation.
    always @(negedge clk) begin
        rsp_t r;
        if (bus.s0_readdatavalid !== 1'b0) begin
            if (sb.size() == 0) begin
                check("rdv_spurious", {127'b0, bus.s0_readdatavalid}, 128'd0);
            end else begin
                r = sb.pop_front();
                check("rd_data", bus.s0_readdata, r.data);
                check("rd_latency", 128'(cyc), 128'(r.due));
            end
        end
    end

    // Drives one command from a negedge, holds it through waitrequest, updates the model at accept.
    task automatic cmd(input logic rd, input logic wr, input logic [13:0] word,
                       input logic [127:0] data, input logic [15:0] be, input logic bc,
                       input logic dbg, input logic [3:0] low, input bit push);
        int   guard = 0;
        bit   in_r, prot, proto;
        rsp_t r;
        bus.s0_read        = rd;
        bus.s0_write       = wr;
        bus.s0_address     = {word, low};
        bus.s0_writedata   = data;
        bus.s0_byteenable  = be;
        bus.s0_burstcount  = bc;
        bus.s0_debugaccess = dbg;
        while (bus.s0_waitrequest !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard == 50) begin
            check("cmd_timeout", {127'b0, bus.s0_waitrequest}, 128'd0);
        end else begin
            in_r  = (word < 14'd256);
            prot  = (word < 14'd16) && !dbg;
            proto = (bc !== 1'b1) || (rd && wr) || (low != 4'd0);
            if ((proto || !in_r || (wr && prot)) && err_m != 16'hFFFF) err_m++;
            if (wr) begin
                if (in_r && !prot) begin
                    for (int i = 0; i < 16; i++) begin
                        if (be[i]) mem_m[word[7:0]][8*i +: 8] = data[8*i +: 8];
                    end
                end
            end else if (push) begin
                r.data = in_r ? mem_m[word[7:0]] : 128'd0;
                r.due  = cyc + 2;
                sb.push_back(r);
            end
        end
        @(negedge clk);
        bus.s0_read  = 1'b0;
        bus.s0_write = 1'b0;
    endtask

    task automatic do_wr(input logic [13:0] w, input logic [127:0] d, input logic [15:0] be,
                         input logic dbg);
        cmd(1'b0, 1'b1, w, d, be, 1'b1, dbg, 4'd0, 1'b1);
    endtask

    task automatic do_rd(input logic [13:0] w);
        cmd(1'b1, 1'b0, w, 128'd0, 16'd0, 1'b1, 1'b0, 4'd0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int pend_m, nrd, accepted, acc, first_wait;
        bus.s0_read = 1'b0;  bus.s0_write = 1'b0;  bus.s0_address = '0;
        bus.s0_writedata = '0;  bus.s0_byteenable = '0;
        bus.s0_burstcount = 1'b1;  bus.s0_debugaccess = 1'b0;
        bus_b.s0_read = 1'b0;  bus_b.s0_write = 1'b0;  bus_b.s0_address = {14'h100, 4'h0};
        bus_b.s0_writedata = '0;  bus_b.s0_byteenable = '0;
        bus_b.s0_burstcount = 1'b1;  bus_b.s0_debugaccess = 1'b0;

        // Reset state and release
        repeat (3) @(negedge clk);
        check("rst_wait", {127'b0, bus.s0_waitrequest}, 128'd1);
        check("rst_rdv", {127'b0, bus.s0_readdatavalid}, 128'd0);
        check("rst_rdata", bus.s0_readdata, 128'd0);
        check("rst_err", {112'b0, err_a}, 128'd0);
        check("rst_pend", {124'b0, dut.pend}, 128'd0);
        rst_n = 1'b1;
        #1 check("rel_wait", {127'b0, bus.s0_waitrequest}, 128'd1);
        @(negedge clk);
        check("rel_wait_next", {127'b0, bus.s0_waitrequest}, 128'd0);

        // Write then immediate read-back
        do_wr(14'h20, 128'h00112233445566778899AABBCCDDEEFF, 16'hFFFF, 1'b0);
        do_rd(14'h20);
        idle(4);
        check("t1_err", {112'b0, err_a}, {112'b0, err_m});

        // Byte-enable merge
        do_wr(14'h30, {128{1'b1}}, 16'hFFFF, 1'b0);
        do_wr(14'h30, 128'd0, 16'h00F0, 1'b0);
        do_rd(14'h30);
        idle(4);

        // Back-to-back reads at default latency stay in order
        for (int k = 0; k < 6; k++) do_rd(k[0] ? 14'h30 : 14'h20);
        idle(4);

        // Outstanding limit on the long-latency instance
        pend_m = 0; nrd = 0; accepted = 0; first_wait = -1;
        bus_b.s0_read = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (accepted == 6) bus_b.s0_read = 1'b0;
            check("b_wait", {127'b0, bus_b.s0_waitrequest}, {127'b0, pend_m == 4});
            if (bus_b.s0_waitrequest && first_wait < 0) first_wait = accepted;
            acc = (bus_b.s0_read && !bus_b.s0_waitrequest) ? 1 : 0;
            if (bus_b.s0_readdatavalid) begin
                nrd++;
                check("b_data", bus_b.s0_readdata, 128'd0);
            end
            pend_m = pend_m + acc - (bus_b.s0_readdatavalid ? 1 : 0);
            accepted += acc;
            @(negedge clk);
        end
        check("b_first_wait_after", 128'(first_wait), 128'd4);
        check("b_rsp_count", 128'(nrd), 128'd6);
        check("b_err", {112'b0, err_b}, 128'd6);

        // Low-region protection
        do_wr(14'h5, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 16'hFFFF, 1'b1);
        do_wr(14'h5, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 16'hFFFF, 1'b0);
        check("prot_err", {112'b0, err_a}, {112'b0, err_m});
        do_rd(14'h5);
        idle(3);
        do_wr(14'h5, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 16'hFFFF, 1'b1);
        check("prot_dbg_err", {112'b0, err_a}, {112'b0, err_m});
        do_rd(14'h5);
        idle(3);

        // Range and protocol errors
        do_rd(14'h100);
        check("oor_rd_err", {112'b0, err_a}, {112'b0, err_m});
        cmd(1'b0, 1'b1, 14'h40, 128'h4040_4040, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b1);
        check("burst_err", {112'b0, err_a}, {112'b0, err_m});
        do_rd(14'h40);
        cmd(1'b1, 1'b1, 14'h41, 128'h4141_4141_4141, 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b1);
        check("rdwr_err", {112'b0, err_a}, {112'b0, err_m});
        do_rd(14'h41);
        cmd(1'b1, 1'b0, 14'h20, 128'd0, 16'd0, 1'b1, 1'b0, 4'h8, 1'b1);
        check("misalign_err", {112'b0, err_a}, {112'b0, err_m});
        do_wr(14'h0, 128'h0BAD_F00D, 16'hFFFF, 1'b1);
        cmd(1'b0, 1'b1, 14'h100, 128'h1234_5678, 16'hFFFF, 1'b1, 1'b1, 4'd0, 1'b1);
        check("oor_wr_err", {112'b0, err_a}, {112'b0, err_m});
        do_rd(14'h0);
        cmd(1'b0, 1'b1, 14'h100, 128'h9999, 16'hFFFF, 1'b0, 1'b1, 4'h4, 1'b1);
        check("multi_err_once", {112'b0, err_a}, {112'b0, err_m});
        idle(4);

        // Reset while a read is in flight
        cmd(1'b1, 1'b0, 14'h20, 128'd0, 16'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        rst_n = 1'b0;
        err_m = 16'd0;
        #1;
        check("mid_rst_wait", {127'b0, bus.s0_waitrequest}, 128'd1);
        check("mid_rst_rdv", {127'b0, bus.s0_readdatavalid}, 128'd0);
        check("mid_rst_pend", {124'b0, dut.pend}, 128'd0);
        check("mid_rst_err", {112'b0, err_a}, 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rel_wait", {127'b0, bus.s0_waitrequest}, 128'd1);
        @(negedge clk);
        check("mid_rel_wait_next", {127'b0, bus.s0_waitrequest}, 128'd0);
        idle(4);
        do_rd(14'h20);
        idle(4);

        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
